// File: rtl/regfile_sb_if.sv
// -----------------------------------------------------------------------------
// regfile_sb_if
//   Bundle of the decode/issue/writeback signals of the scoreboarded register
//   file.
//   master : decode/issue/writeback side; drives indices, write data, issue.
//   slave  : the register file; returns read data, busy flags, busy_count,
//            err_reissue.
// -----------------------------------------------------------------------------
interface regfile_sb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  // Read ports
  logic [ADDR_WIDTH-1:0] ctrl_readRegA;
  logic [ADDR_WIDTH-1:0] ctrl_readRegB;
  logic [DATA_WIDTH-1:0] data_readRegA;
  logic [DATA_WIDTH-1:0] data_readRegB;
  logic                  busy_readRegA;
  logic                  busy_readRegB;
  // Writeback port
  logic                  ctrl_writeEnable;
  logic [ADDR_WIDTH-1:0] ctrl_writeReg;
  logic [DATA_WIDTH-1:0] data_writeReg;
  // Issue port
  logic                  ctrl_issue;
  logic [ADDR_WIDTH-1:0] ctrl_issueReg;
  // Status
  logic [ADDR_WIDTH:0]   busy_count;
  logic                  err_reissue;

  modport master (
    output ctrl_readRegA, ctrl_readRegB,
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output ctrl_issue, ctrl_issueReg,
    input  data_readRegA, data_readRegB, busy_readRegA, busy_readRegB,
    input  busy_count, err_reissue
  );

  modport slave (
    input  ctrl_readRegA, ctrl_readRegB,
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  ctrl_issue, ctrl_issueReg,
    output data_readRegA, data_readRegB, busy_readRegA, busy_readRegB,
    output busy_count, err_reissue
  );
endinterface

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
//   Two-read / one-write register file with same-cycle write-to-read bypass
//   and a per-register busy scoreboard for pending writebacks.
//   clock        : rising-edge clock for all state.
//   ctrl_reset_n : asynchronous active-low reset; clears data, busy bits,
//                  busy_count and err_reissue.
//   bus (slave)  : read indices/data/busy (combinational), writeback strobe,
//                  issue reservation, registered busy_count and err_reissue.
// -----------------------------------------------------------------------------
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic          clock,
  input  logic          ctrl_reset_n,
  regfile_sb_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]      busy_q, busy_d;
  logic [ADDR_WIDTH:0]   busy_count_q, busy_count_d;
  logic                  err_reissue_q, err_reissue_d;

  // Effective strobes: with a hard-wired R0, writes and issues aimed at it
  // vanish entirely.
  logic wr_ok, is_ok;
  assign wr_ok = bus.ctrl_writeEnable &
                 ~(ZERO_REG && (bus.ctrl_writeReg == '0));
  assign is_ok = bus.ctrl_issue &
                 ~(ZERO_REG && (bus.ctrl_issueReg == '0));

  // Next-state computation.
  always_comb begin
    // NOTE: every variable is given a default before any conditional update;
    // otherwise an unassigned path would infer a latch.
    regs_d        = regs_q;
    busy_d        = busy_q;
    err_reissue_d = 1'b0;

    if (wr_ok) begin
      regs_d[bus.ctrl_writeReg] = bus.data_writeReg;
      busy_d[bus.ctrl_writeReg] = 1'b0;
    end
    // Issue is applied after the write so a same-cycle issue/write to one
    // register leaves it busy: the new producer owns it.
    if (is_ok) begin
      busy_d[bus.ctrl_issueReg] = 1'b1;
      err_reissue_d = busy_q[bus.ctrl_issueReg] &
                      ~(wr_ok && (bus.ctrl_writeReg == bus.ctrl_issueReg));
    end
  end

  // Popcount of the post-update busy vector, registered below.
  always_comb begin
    busy_count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_count_d = busy_count_d + (ADDR_WIDTH+1)'(busy_d[i]);
    end
  end

  // NOTE: the register array is reset along with the control state because
  // the block must read all-zero while reset is held; this keeps it in flops
  // rather than a RAM macro.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q        <= '0;
      busy_count_q  <= '0;
      err_reissue_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      regs_q        <= regs_d;
      busy_q        <= busy_d;
      busy_count_q  <= busy_count_d;
      err_reissue_q <= err_reissue_d;
    end
  end

  // Read ports: R0 forced to zero, then bypass from the writeback port, then
  // the stored value. A completing write hides the busy bit in the same cycle
  // so data and busy agree.
  logic hit_a, hit_b, zero_a, zero_b;
  assign hit_a  = bus.ctrl_writeEnable && (bus.ctrl_writeReg == bus.ctrl_readRegA);
  assign hit_b  = bus.ctrl_writeEnable && (bus.ctrl_writeReg == bus.ctrl_readRegB);
  assign zero_a = ZERO_REG && (bus.ctrl_readRegA == '0);
  assign zero_b = ZERO_REG && (bus.ctrl_readRegB == '0);

  always_comb begin
    if (zero_a)     bus.data_readRegA = '0;
    else if (hit_a) bus.data_readRegA = bus.data_writeReg;
    else            bus.data_readRegA = regs_q[bus.ctrl_readRegA];

    if (zero_b)     bus.data_readRegB = '0;
    else if (hit_b) bus.data_readRegB = bus.data_writeReg;
    else            bus.data_readRegB = regs_q[bus.ctrl_readRegB];
  end

  assign bus.busy_readRegA = busy_q[bus.ctrl_readRegA] & ~hit_a;
  assign bus.busy_readRegB = busy_q[bus.ctrl_readRegB] & ~hit_b;
  assign bus.busy_count    = busy_count_q;
  assign bus.err_reissue   = err_reissue_q;

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
//   Scoreboard bench for regfile_sb (DATA_WIDTH=32, ADDR_WIDTH=5, ZERO_REG=1).
//   The stimulus process drives one set of inputs per cycle and pushes the
//   reference model's expected outputs into a queue; a monitor process pops
//   and compares on every falling edge.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b1)) dut (
    .clock        (clk),
    .ctrl_reset_n (rst_n),
    .bus          (bus.slave)
  );

  typedef struct {
    logic [DW-1:0] data_a, data_b;
    logic          busy_a, busy_b;
    logic [AW:0]   count;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: architectural register contents and pending writes.
  logic [DW-1:0] m_mem  [N];
  logic          m_busy [N];
  int            m_count;
  logic          m_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_count = 0;
    m_err   = 1'b0;
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (bus.ctrl_writeEnable && bus.ctrl_writeReg == a) return bus.data_writeReg;
    return m_mem[a];
  endfunction

  function automatic logic model_busy(input logic [AW-1:0] a);
    return m_busy[a] && !(bus.ctrl_writeEnable && bus.ctrl_writeReg == a);
  endfunction

  // Apply one clock edge's worth of architectural effect from the inputs
  // presented during the cycle that just ended.
  function automatic void model_edge();
    logic released, wr, iss;
    wr  = bus.ctrl_writeEnable && bus.ctrl_writeReg != 0;
    iss = bus.ctrl_issue && bus.ctrl_issueReg != 0;
    released = wr && bus.ctrl_writeReg == bus.ctrl_issueReg;
    m_err = iss && m_busy[bus.ctrl_issueReg] && !released;
    if (wr) begin
      m_mem[bus.ctrl_writeReg]  = bus.data_writeReg;
      m_busy[bus.ctrl_writeReg] = 1'b0;
    end
    if (iss) m_busy[bus.ctrl_issueReg] = 1'b1;
    m_count = 0;
    for (int i = 0; i < N; i++) m_count += int'(m_busy[i]);
  endfunction

  task automatic drive_idle();
    bus.ctrl_writeEnable = 1'b0;
    bus.ctrl_writeReg    = '0;
    bus.data_writeReg    = '0;
    bus.ctrl_issue       = 1'b0;
    bus.ctrl_issueReg    = '0;
    bus.ctrl_readRegA    = '0;
    bus.ctrl_readRegB    = '0;
  endtask

  // One cycle: commit the previous cycle's inputs to the model at the edge,
  // drive the new inputs, queue the expected outputs, and return just after
  // the falling edge so the caller may add directed checks.
  task automatic cycle(input logic we, input logic [AW-1:0] wreg, input logic [DW-1:0] wd,
                       input logic iss, input logic [AW-1:0] ireg,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    bus.ctrl_writeEnable = we;
    bus.ctrl_writeReg    = wreg;
    bus.data_writeReg    = wd;
    bus.ctrl_issue       = iss;
    bus.ctrl_issueReg    = ireg;
    bus.ctrl_readRegA    = ra;
    bus.ctrl_readRegB    = rb;
    e.data_a = model_read(ra);
    e.data_b = model_read(rb);
    e.busy_a = model_busy(ra);
    e.busy_b = model_busy(rb);
    e.count  = (AW+1)'(m_count);
    e.err    = m_err;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  // Monitor: outputs are valid every cycle; compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_data_a", 64'(bus.data_readRegA), 64'(e.data_a));
        check("sb_data_b", 64'(bus.data_readRegB), 64'(e.data_b));
        check("sb_busy_a", 64'(bus.busy_readRegA), 64'(e.busy_a));
        check("sb_busy_b", 64'(bus.busy_readRegB), 64'(e.busy_b));
        check("sb_count",  64'(bus.busy_count),    64'(e.count));
        check("sb_err",    64'(bus.err_reissue),   64'(e.err));
      end
    end
  end

  // Watchdog: the run is a fixed number of cycles; this only guards a stall.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    model_reset();
    rst_n = 1'b0;
    #12;
    // Reset state: every index reads zero and idle.
    for (int i = 0; i < N; i++) begin
      bus.ctrl_readRegA = AW'(i);
      bus.ctrl_readRegB = AW'(N - 1 - i);
      #1;
      check("rst_data_a", 64'(bus.data_readRegA), 64'd0);
      check("rst_busy_b", 64'(bus.busy_readRegB), 64'd0);
    end
    check("rst_count", 64'(bus.busy_count), 64'd0);
    check("rst_err",   64'(bus.err_reissue), 64'd0);
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;

    // Write with same-cycle bypass, then stored value.
    cycle(1, 5, 32'hDEADBEEF, 0, 0, 5, 0);
    check("bypass_r5", 64'(bus.data_readRegA), 64'hDEADBEEF);
    cycle(1, 0, 32'h1234, 0, 0, 0, 5);
    check("r0_bypass_zero", 64'(bus.data_readRegA), 64'd0);
    check("r5_stored", 64'(bus.data_readRegB), 64'hDEADBEEF);
    cycle(0, 0, 0, 0, 0, 0, 5);
    check("r0_after_write", 64'(bus.data_readRegA), 64'd0);

    // Issue R7: busy from the next cycle, cleared by the completing write.
    cycle(0, 0, 0, 1, 7, 5, 7);
    check("issue_same_cycle_busy", 64'(bus.busy_readRegB), 64'd0);
    cycle(0, 0, 0, 0, 0, 5, 7);
    check("r7_busy", 64'(bus.busy_readRegB), 64'd1);
    check("count_1", 64'(bus.busy_count), 64'd1);
    cycle(1, 7, 32'h55, 0, 0, 5, 7);
    check("r7_busy_clears_in_write", 64'(bus.busy_readRegB), 64'd0);
    check("r7_bypass", 64'(bus.data_readRegB), 64'h55);
    cycle(0, 0, 0, 0, 0, 5, 7);
    check("count_0", 64'(bus.busy_count), 64'd0);

    // Issue and write the same register together: issue wins.
    cycle(1, 3, 32'hA, 1, 3, 3, 0);
    cycle(0, 0, 0, 0, 0, 3, 0);
    check("r3_data", 64'(bus.data_readRegA), 64'hA);
    check("r3_busy", 64'(bus.busy_readRegA), 64'd1);
    check("r3_count", 64'(bus.busy_count), 64'd1);
    check("r3_no_err", 64'(bus.err_reissue), 64'd0);
    cycle(1, 3, 32'hA, 0, 0, 3, 0);

    // Reissue R9: one-cycle error pulse, count stays 1.
    cycle(0, 0, 0, 1, 9, 0, 9);
    cycle(0, 0, 0, 1, 9, 0, 9);
    cycle(0, 0, 0, 0, 0, 0, 9);
    check("reissue_err", 64'(bus.err_reissue), 64'd1);
    check("reissue_count", 64'(bus.busy_count), 64'd1);
    cycle(0, 0, 0, 0, 0, 0, 9);
    check("reissue_err_pulse", 64'(bus.err_reissue), 64'd0);
    check("reissue_count_hold", 64'(bus.busy_count), 64'd1);
    cycle(1, 9, 32'h9, 0, 0, 0, 9);

    // Random traffic; addresses biased to a small window for collisions.
    for (int k = 0; k < 3000; k++) begin
      logic [AW-1:0] wr, ir, ra, rb;
      wr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      ir = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      ra = AW'($urandom_range(0, 9));
      rb = ($urandom_range(0, 1) == 0) ? wr : AW'($urandom);
      cycle(1'($urandom), wr, $urandom, 1'($urandom), ir, ra, rb);
    end

    // Fill the scoreboard R1..R31, then reset asynchronously mid-cycle.
    for (int r = 1; r < N; r++) cycle(1, AW'(r), 32'(r * 3 + 1), 0, 0, 0, 0);
    for (int r = 1; r < N; r++) cycle(0, 0, 0, 1, AW'(r), AW'(r), 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check("full_count", 64'(bus.busy_count), 64'(N - 1));
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_count", 64'(bus.busy_count), 64'd0);
    check("async_rst_err",   64'(bus.err_reissue), 64'd0);
    for (int i = 0; i < N; i++) begin
      bus.ctrl_readRegA = AW'(i);
      bus.ctrl_readRegB = AW'(i);
      #1;
      check("async_rst_data", 64'(bus.data_readRegA), 64'd0);
      check("async_rst_busy", 64'(bus.busy_readRegB), 64'd0);
    end
    // Bypass stays live while reset is held.
    bus.ctrl_writeEnable = 1'b1;
    bus.ctrl_writeReg    = 4;
    bus.data_writeReg    = 32'hCAFE_F00D;
    bus.ctrl_readRegA    = 4;
    #1;
    check("rst_bypass", 64'(bus.data_readRegA), 64'hCAFEF00D);
    drive_idle();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Post-reset traffic: writebacks of discarded reservations are plain writes.
    for (int k = 0; k < 500; k++) begin
      cycle(1'($urandom), AW'($urandom), $urandom, 1'($urandom_range(0, 3) == 0),
            AW'($urandom), AW'($urandom), AW'($urandom));
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
